// File: rtl/fc_sequencer_pkg.sv
// Shared parameters, state encoding and pipeline tag type for the FC sequencer.
// Defaults here are the nominal network shape; instances may override them.
package fc_sequencer_pkg;

  localparam int FM_DEPTH_DEF    = 64;
  localparam int NUM_KERNELS_DEF = 2;
  localparam int PIPE_LAT_DEF    = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FM_AW_DEF = idx_width(FM_DEPTH_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } fc_state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } issue_tag_t;

endpackage

// File: rtl/fc_sequencer_valid_delay_sr.sv
// Delays the (valid, last) issue tag by DEPTH cycles to line up with mux read data.
// No backpressure; synchronous reset flushes every stage so aborted passes leave no trace.
module valid_delay_sr
  import fc_sequencer_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  issue_tag_t d,
  output issue_tag_t q
);

  issue_tag_t sr [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fc_sequencer.sv
// Sequences one classifier pass: clear, issue all (addr, kernel) reads, drain, hand off.
// Issue takes FM_DEPTH*NUM_KERNELS cycles; result held in DONE until result_ack.
module fc_sequencer
  import fc_sequencer_pkg::*;
#(
  parameter int FM_DEPTH    = FM_DEPTH_DEF,
  parameter int NUM_KERNELS = NUM_KERNELS_DEF,
  parameter int PIPE_LAT    = PIPE_LAT_DEF
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             result_ack,
  output logic [idx_width(FM_DEPTH)-1:0]    rd_addr,
  output logic [idx_width(NUM_KERNELS)-1:0] ram_select,
  output logic                             mac_clear,
  output logic                             mac_en,
  output logic                             mac_last,
  output logic                             product_rdy,
  output logic                             fm_release,
  output logic                             busy
);

  localparam int AW = idx_width(FM_DEPTH);
  localparam int SW = idx_width(NUM_KERNELS);
  localparam int DW = idx_width(PIPE_LAT);

  localparam logic [AW-1:0] ADDR_LAST  = AW'(FM_DEPTH - 1);
  localparam logic [SW-1:0] SEL_LAST   = SW'(NUM_KERNELS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

  fc_state_t     state;
  logic [DW-1:0] drain_cnt;
  logic          issue_valid;
  logic          last_pair;
  issue_tag_t    tag_in;
  issue_tag_t    tag_out;

  assign issue_valid = (state == ST_RUN);
  assign last_pair   = issue_valid && (rd_addr == ADDR_LAST) && (ram_select == SEL_LAST);
  assign tag_in      = {issue_valid, last_pair};

  valid_delay_sr #(
    .DEPTH(PIPE_LAT)
  ) u_valid_delay_sr (
    .clock(clock),
    .reset(reset),
    .d    (tag_in),
    .q    (tag_out)
  );

  assign mac_en   = tag_out.valid;
  assign mac_last = tag_out.last;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      rd_addr     <= '0;
      ram_select  <= '0;
      drain_cnt   <= '0;
      mac_clear   <= 1'b0;
      product_rdy <= 1'b0;
      fm_release  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mac_clear  <= 1'b0;
      fm_release <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_CLEAR;
            rd_addr    <= '0;
            ram_select <= '0;
            mac_clear  <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          // Kernel select is the inner loop; the address advances on its wrap.
          if (last_pair) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end else if (ram_select == SEL_LAST) begin
            ram_select <= '0;
            rd_addr    <= rd_addr + AW'(1);
          end else begin
            ram_select <= ram_select + SW'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state       <= ST_DONE;
            product_rdy <= 1'b1;
            fm_release  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        ST_DONE: begin
          if (result_ack) begin
            state       <= ST_IDLE;
            product_rdy <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          product_rdy <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_sequencer.sv
// Directed bench: nominal pass from a cycle table, then multi-cycle corner sequences.
module tb_fc_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic result_ack = 1'b0;
  logic start3 = 1'b0;
  logic ack3 = 1'b0;

  logic [1:0] rd_addr;
  logic       ram_select;
  logic       mac_clear, mac_en, mac_last, product_rdy, fm_release, busy;

  logic [1:0] rd_addr3;
  logic [1:0] ram_select3;
  logic       mac_clear3, mac_en3, mac_last3, product_rdy3, fm_release3, busy3;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  fc_sequencer #(.FM_DEPTH(4), .NUM_KERNELS(2), .PIPE_LAT(2)) dut (
    .clock(clock), .reset(reset), .start(start), .result_ack(result_ack),
    .rd_addr(rd_addr), .ram_select(ram_select), .mac_clear(mac_clear),
    .mac_en(mac_en), .mac_last(mac_last), .product_rdy(product_rdy),
    .fm_release(fm_release), .busy(busy)
  );

  fc_sequencer #(.FM_DEPTH(3), .NUM_KERNELS(3), .PIPE_LAT(2)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .result_ack(ack3),
    .rd_addr(rd_addr3), .ram_select(ram_select3), .mac_clear(mac_clear3),
    .mac_en(mac_en3), .mac_last(mac_last3), .product_rdy(product_rdy3),
    .fm_release(fm_release3), .busy(busy3)
  );

  typedef struct packed {
    logic       busy;
    logic       mac_clear;
    logic       mac_en;
    logic       mac_last;
    logic       product_rdy;
    logic       fm_release;
    logic [1:0] rd_addr;
    logic       ram_select;
  } obs_t;

  typedef struct packed {
    logic start;
    logic ack;
    obs_t exp;
  } vec_t;

  obs_t obs;
  assign obs = {busy, mac_clear, mac_en, mac_last, product_rdy, fm_release, rd_addr, ram_select};

  localparam obs_t RESET_OBS = '0;

  function automatic vec_t mk(input logic st, input logic ak, input logic bsy, input logic clr,
                              input logic en, input logic lst, input logic pr, input logic rl,
                              input logic [1:0] ad, input logic sl);
    vec_t v;
    v.start = st;
    v.ack   = ak;
    v.exp   = {bsy, clr, en, lst, pr, rl, ad, sl};
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; start = 1'b0; result_ack = 1'b0; start3 = 1'b0; ack3 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  vec_t vecs[16];

  initial begin
    int clr_cnt, en_cnt, rel_cnt, prdy_cnt, idle_cnt, bad_seq, max_a, max_s, last_cyc;
    logic clr14, clr27;

    // Nominal pass, FM_DEPTH=4 NUM_KERNELS=2 PIPE_LAT=2; row index = cycle.
    //            st ak bsy clr en lst pr rl addr sel
    vecs[0]  = mk(1, 0, 0,  0,  0, 0,  0, 0, 2'd0, 0);
    vecs[1]  = mk(0, 0, 1,  1,  0, 0,  0, 0, 2'd0, 0);
    vecs[2]  = mk(0, 0, 1,  0,  0, 0,  0, 0, 2'd0, 0);
    vecs[3]  = mk(0, 0, 1,  0,  0, 0,  0, 0, 2'd0, 1);
    vecs[4]  = mk(0, 0, 1,  0,  1, 0,  0, 0, 2'd1, 0);
    vecs[5]  = mk(0, 0, 1,  0,  1, 0,  0, 0, 2'd1, 1);
    vecs[6]  = mk(0, 0, 1,  0,  1, 0,  0, 0, 2'd2, 0);
    vecs[7]  = mk(0, 0, 1,  0,  1, 0,  0, 0, 2'd2, 1);
    vecs[8]  = mk(0, 0, 1,  0,  1, 0,  0, 0, 2'd3, 0);
    vecs[9]  = mk(0, 0, 1,  0,  1, 0,  0, 0, 2'd3, 1);
    vecs[10] = mk(0, 0, 1,  0,  1, 0,  0, 0, 2'd3, 1);
    vecs[11] = mk(0, 0, 1,  0,  1, 1,  0, 0, 2'd3, 1);
    vecs[12] = mk(0, 0, 1,  0,  0, 0,  1, 1, 2'd3, 1);
    vecs[13] = mk(0, 1, 1,  0,  0, 0,  1, 0, 2'd3, 1);
    vecs[14] = mk(0, 0, 0,  0,  0, 0,  0, 0, 2'd3, 1);
    vecs[15] = mk(0, 0, 0,  0,  0, 0,  0, 0, 2'd3, 1);

    do_reset();
    check("reset_state", int'(obs), int'(RESET_OBS));

    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clock);
      start = vecs[i].start;
      result_ack = vecs[i].ack;
      check($sformatf("nominal_cycle_%0d", i), int'(obs), int'(vecs[i].exp));
    end

    // Ack withheld 20 cycles; spurious start in RUN and DONE must be ignored.
    clr_cnt = 0; en_cnt = 0; rel_cnt = 0; prdy_cnt = 0;
    for (int c = 0; c <= 34; c++) begin
      @(negedge clock);
      start = (c == 0) || (c >= 3 && c <= 8) || (c == 20);
      result_ack = (c == 32);
      if (mac_clear) clr_cnt++;
      if (mac_en) en_cnt++;
      if (fm_release) rel_cnt++;
      if (c >= 12 && c <= 32 && product_rdy) prdy_cnt++;
      if (c == 1) check("clear_resets_counters", {rd_addr, ram_select}, 0);
      if (c == 33) check("ack_hold_busy_low_c33", busy, 0);
      if (c == 34) check("ack_hold_no_queued_start", busy, 0);
    end
    start = 1'b0; result_ack = 1'b0;
    check("ack_hold_prdy_cycles", prdy_cnt, 21);
    check("ack_hold_single_release", rel_cnt, 1);
    check("ack_hold_single_clear", clr_cnt, 1);
    check("ack_hold_mac_en_count", en_cnt, 8);

    // start and result_ack held high: back-to-back passes, one IDLE cycle between.
    clr_cnt = 0; en_cnt = 0; idle_cnt = 0; clr14 = 1'b0; clr27 = 1'b0;
    for (int c = 0; c <= 39; c++) begin
      @(negedge clock);
      start = (c < 39);
      result_ack = (c < 39);
      if (mac_clear) clr_cnt++;
      if (mac_en) en_cnt++;
      if (c >= 1 && c <= 38 && !busy) idle_cnt++;
      if (c == 14) clr14 = mac_clear;
      if (c == 27) clr27 = mac_clear;
    end
    start = 1'b0; result_ack = 1'b0;
    check("b2b_clear_count", clr_cnt, 3);
    check("b2b_second_clear_c14", clr14, 1);
    check("b2b_third_clear_c27", clr27, 1);
    check("b2b_idle_gaps", idle_cnt, 2);
    check("b2b_mac_en_count", en_cnt, 24);

    // Reset asserted mid-RUN at cycle 5.
    en_cnt = 0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clock);
      start = (c == 0);
      reset = (c == 5);
      if (c == 6) check("midrun_reset_outputs", int'(obs), int'(RESET_OBS));
      if (c >= 6 && mac_en) en_cnt++;
    end
    reset = 1'b0; start = 1'b0;
    check("midrun_reset_no_mac_en", en_cnt, 0);

    // start and result_ack together in DONE: back to IDLE, no new pass until fresh start.
    clr_cnt = 0; idle_cnt = 0;
    for (int c = 0; c <= 22; c++) begin
      @(negedge clock);
      start = (c == 0) || (c == 12) || (c == 21);
      result_ack = (c == 12);
      if (c == 12) check("simul_done_prdy_rel", {product_rdy, fm_release}, 3);
      if (c >= 13 && c <= 21) begin
        if (mac_clear) clr_cnt++;
        if (!busy) idle_cnt++;
      end
      if (c == 22) check("simul_fresh_start_clear", {busy, mac_clear}, 3);
    end
    start = 1'b0; result_ack = 1'b0;
    check("simul_no_clear_while_idle", clr_cnt, 0);
    check("simul_idle_cycles", idle_cnt, 9);

    // Non-power-of-2 shape on the second instance: 3 addresses x 3 kernels.
    en_cnt = 0; bad_seq = 0; max_a = 0; max_s = 0; last_cyc = -1; prdy_cnt = 0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clock);
      start3 = (c == 0);
      ack3 = (c == 13);
      if (mac_en3) en_cnt++;
      if (mac_last3) last_cyc = c;
      if (int'(rd_addr3) > max_a) max_a = int'(rd_addr3);
      if (int'(ram_select3) > max_s) max_s = int'(ram_select3);
      if (c >= 2 && c <= 10 &&
          (int'(rd_addr3) != (c - 2) / 3 || int'(ram_select3) != (c - 2) % 3)) bad_seq++;
      if (c == 13 && product_rdy3) prdy_cnt++;
      if (c == 14) check("np2_busy_low_after_ack", busy3, 0);
    end
    start3 = 1'b0; ack3 = 1'b0;
    check("np2_issue_order", bad_seq, 0);
    check("np2_max_addr", max_a, 2);
    check("np2_max_sel", max_s, 2);
    check("np2_mac_en_count", en_cnt, 9);
    check("np2_mac_last_cycle", last_cyc, 12);
    check("np2_prdy_c13", prdy_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fc_sequencer.md
FC_SEQUENCER -- requirements
Module: fc_sequencer

Interface
REQ-001 Parameter FM_DEPTH, default 64: feature-map words per kernel buffer; minimum 1.
REQ-002 Parameter NUM_KERNELS, default 2: number of kernel buffers behind the read-port mux; minimum 1.
REQ-003 Parameter PIPE_LAT, default 2: cycles from address issue to mux data valid (RAM read plus registered mux); minimum 1.
REQ-004 Port clock, input, 1 bit: single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start, input, 1 bit: feature-map buffer full; sampled only in IDLE.
REQ-007 Port result_ack, input, 1 bit: consumer has taken the classifier sums.
REQ-008 Port rd_addr, output, clog2(FM_DEPTH) bits (min 1): read address to all fm/weight buffers.
REQ-009 Port ram_select, output, clog2(NUM_KERNELS) bits (min 1): read-port mux select.
REQ-010 Port mac_clear, output, 1 bit: clear all matrix-multiply accumulators.
REQ-011 Port mac_en, output, 1 bit: mux data valid; accumulate this cycle.
REQ-012 Port mac_last, output, 1 bit: qualifies the final mac_en of a pass.
REQ-013 Port product_rdy, output, 1 bit: sums final and stable.
REQ-014 Port fm_release, output, 1 bit: one-cycle pulse; fm buffer may be refilled.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 FSM states are IDLE, CLEAR, RUN, DRAIN, DONE; all outputs are registered.
REQ-017 IDLE with start=1 goes to CLEAR next cycle; start in any other state is ignored, with no queuing.
REQ-018 CLEAR lasts exactly 1 cycle with mac_clear=1, then goes to RUN.
REQ-019 RUN lasts exactly N = FM_DEPTH*NUM_KERNELS cycles and issues one (rd_addr, ram_select) pair per cycle.
REQ-020 Issue order: ram_select is the inner loop (0..NUM_KERNELS-1) and rd_addr the outer loop (0..FM_DEPTH-1); both start at 0.
REQ-021 ram_select wraps to 0 and rd_addr increments when ram_select = NUM_KERNELS-1.
REQ-022 RUN goes to DRAIN after the pair (FM_DEPTH-1, NUM_KERNELS-1) is issued.
REQ-023 An internal issue_valid is 1 exactly during RUN cycles.
REQ-024 mac_en equals issue_valid delayed by PIPE_LAT cycles.
REQ-025 mac_last equals (issue_valid AND last pair) delayed by PIPE_LAT cycles.
REQ-026 DRAIN lasts exactly PIPE_LAT cycles, then goes to DONE.
REQ-027 On DONE entry, fm_release pulses for 1 cycle; product_rdy=1 for the whole of DONE.
REQ-028 DONE holds until result_ack=1, then goes to IDLE next cycle with product_rdy=0.
REQ-029 result_ack outside DONE is ignored.
REQ-030 start and result_ack high in the same cycle in DONE: return to IDLE only; a new pass needs start asserted in IDLE.
REQ-031 rd_addr and ram_select hold their last issued values outside RUN and return to 0 at the next CLEAR.
REQ-032 Counter compares are exact; there is no modulo-2^n wrap for non-power-of-2 FM_DEPTH or NUM_KERNELS.

Reset
REQ-033 reset=1 forces IDLE on the next edge, from any state, including mid-RUN or mid-DRAIN.
REQ-034 Reset values: rd_addr=0, ram_select=0, mac_clear=0, mac_en=0, mac_last=0, product_rdy=0, fm_release=0, busy=0.
REQ-035 Reset clears the PIPE_LAT delay line, so no mac_en from an aborted pass appears after reset.

Structure
REQ-036 The state encoding and the FM_DEPTH/NUM_KERNELS/PIPE_LAT defaults live in the shared network params package, alongside the FM address width.
REQ-037 One sub-module, valid_delay_sr, provides a PIPE_LAT-deep, 2-bit-wide shift register (valid, last) with synchronous reset.

Verification
All cycle numbers are relative to the cycle in which start is sampled (cycle 0), with FM_DEPTH=4, NUM_KERNELS=2, PIPE_LAT=2.
REQ-038 Nominal pass:
  - mac_clear at cycle 1.
  - RUN at cycles 2-9 with (addr,sel) = (0,0),(0,1),(1,0),(1,1),(2,0),(2,1),(3,0),(3,1).
  - mac_en at cycles 4-11, mac_last at cycle 11.
  - product_rdy and fm_release at cycle 12.
REQ-039 Ack hold: result_ack withheld 20 cycles -> product_rdy stays 1 and fm_release stays a single pulse; ack at cycle 32 -> busy=0 at cycle 33.
REQ-040 start held high continuously -> passes run back-to-back, with exactly one IDLE cycle between DONE exit and the next CLEAR; no start during RUN is counted.
REQ-041 reset at cycle 5 (mid-RUN) -> cycle 6 has all outputs at reset values and mac_en stays 0 through cycle 10.
REQ-042 Non-power-of-2 parameters: FM_DEPTH=3, NUM_KERNELS=3 -> 9 issues; addr never exceeds 2 and sel never exceeds 2; exactly 9 mac_en pulses.
REQ-043 Simultaneous start and result_ack in DONE -> IDLE next cycle, no CLEAR until a fresh start arrives.
